// File: rtl/buf8_reader.sv
// buf8_reader: fill-then-drain buffer reader.
// Collects DEPTH entries from a writer (FILL), then streams them out in write
// order over a valid/ready handshake (DRAIN). Writes arriving while draining
// are discarded and latch a sticky drop_err flag.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   wr_en, wr_data      one entry per cycle from the writer
//   dout, dout_valid    entry presented to the consumer (registered)
//   dout_ready          consumer accepts dout this cycle
//   full                buffer complete, drain in progress (registered)
//   drop_err            sticky: a write was discarded (registered)
module buf8_reader #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             full,
   output logic             drop_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   typedef enum logic {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             full_q, full_d;
   logic             drop_err_q, drop_err_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             mem_we_c;
   logic [PTR_W-1:0] rd_nxt_c;

   assign rd_nxt_c = PTR_W'(rd_ptr_q + PTR_W'(1));

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      full_d       = full_q;
      drop_err_d   = drop_err_q;
      mem_we_c     = 1'b0;

      case (state_q)
         S_FILL: begin
            if (wr_en) begin
               mem_we_c = 1'b1;
               wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
               if (wr_ptr_q == LAST) begin
                  // Final entry written: entry 0 is already stored, present it next cycle
                  state_d      = S_DRAIN;
                  wr_ptr_d     = '0;
                  dout_d       = mem_q[rd_ptr_q];
                  dout_valid_d = 1'b1;
                  full_d       = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (wr_en) begin
               drop_err_d = 1'b1;
            end
            if (dout_valid_q && dout_ready) begin
               if (rd_ptr_q == LAST) begin
                  state_d      = S_FILL;
                  rd_ptr_d     = '0;
                  dout_d       = '0;
                  dout_valid_d = 1'b0;
                  full_d       = 1'b0;
               end else begin
                  rd_ptr_d = rd_nxt_c;
                  dout_d   = mem_q[rd_nxt_c];
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // State and control registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_FILL;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         full_q       <= 1'b0;
         drop_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         full_q       <= full_d;
         drop_err_q   <= drop_err_d;
      end
   end

   // Entry storage, cleared on reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we_c) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign full       = full_q;
   assign drop_err   = drop_err_q;

endmodule

// File: doc/buf8_reader.md
BUF8_READER -- requirements
Module: buf8_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffer entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 4, bits per entry.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe from the buffer writer, one entry per cycle.
REQ-006 SHALL have port wr_data  input  WIDTH  entry value written when wr_en=1.
REQ-007 SHALL have port dout  output  WIDTH  entry currently presented to the consumer.
REQ-008 SHALL have port dout_valid  output  1  dout holds a valid entry.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 SHALL have port full  output  1  all DEPTH entries written, drain in progress.
REQ-011 SHALL have port drop_err  output  1  sticky flag: a write was discarded.

Function
REQ-012 SHALL implement a two-state FSM: FILL (accept writes) and DRAIN (stream entries out).
REQ-013 In FILL, wr_en=1 at a posedge SHALL store wr_data at mem[wr_ptr] and increment wr_ptr.
REQ-014 The write that stores entry DEPTH-1 SHALL move the FSM to DRAIN at that same edge, with wr_ptr wrapping to 0.
REQ-015 In DRAIN, full SHALL be 1, and dout_valid SHALL be 1 with dout=mem[rd_ptr], all registered; dout_valid first rises the cycle after the final write edge.
REQ-016 A handshake (dout_valid & dout_ready at posedge) SHALL advance rd_ptr; the next entry SHALL appear the following cycle with no idle cycle between entries.
REQ-017 Without dout_ready, dout and dout_valid SHALL hold unchanged indefinitely.
REQ-018 The handshake on entry DEPTH-1 SHALL return the FSM to FILL: rd_ptr wraps to 0, and dout_valid and full drop in the next cycle.
REQ-019 wr_en=1 sampled while in DRAIN, including the cycle of the final handshake, SHALL be discarded, leave mem unchanged, and set drop_err.
REQ-020 drop_err SHALL remain 1 until reset.
REQ-021 Entries SHALL be read in write order (index 0 first); values pass through unmodified.
REQ-022 A partial fill (<DEPTH writes) SHALL never assert dout_valid; the pointer holds between sparse writes.
REQ-023 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-024 rstn=0 SHALL immediately, regardless of clk, force: FILL state, wr_ptr=0, rd_ptr=0, dout=0, dout_valid=0, full=0, drop_err=0.
REQ-025 mem contents SHALL be cleared to 0 on reset.
REQ-026 Reset asserted mid-fill or mid-drain SHALL abandon the operation; the first write after release SHALL go to entry 0.
REQ-027 The first posedge after rstn rises SHALL already accept wr_en.

Verification
REQ-028 Write 1..8 on consecutive cycles, dout_ready=1 -> dout 1,2,...,8 with dout_valid=1 for exactly 8 consecutive cycles, starting 1 cycle after the 8th write; then full=0.
REQ-029 Fill with 8 values, dout_ready toggling 1/0 each cycle -> each value is held while ready=0; sequence is unchanged and completes in 16 cycles.
REQ-030 Fill, then drive wr_en=1, wr_data=F during drain -> drop_err=1 and stays 1; drained data does not contain F.
REQ-031 Write 5 entries, idle 20 cycles, write 3 more -> dout_valid stays 0 until the 3rd extra write, then all 8 values drain in order.
REQ-032 Assert rstn=0 mid-drain between clock edges -> all outputs are 0 immediately; after release, a new 8-write fill drains from entry 0.
REQ-033 Drive wr_en=1 in the same cycle as the final handshake -> that write is dropped and drop_err=1; the next-cycle write lands in entry 0.
